shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 88 ++++++++
 tb/tb_shift_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle right shifter: moves the operand at most STEP bit positions per
// clock, filling with zeros (logical) or with the sign bit (arithmetic).
module shift_sequencer #(
  parameter int DATA_WIDTH = 20,
  parameter int STEP       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] shift_amount,
  input  logic                  arith,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int RW       = $clog2(DATA_WIDTH + 1);
  localparam int STEP_EFF = (STEP < DATA_WIDTH) ? STEP : DATA_WIDTH;
  localparam logic [RW-1:0] REM_FULL = RW'(DATA_WIDTH);
  localparam logic [RW-1:0] REM_STEP = RW'(STEP_EFF);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] work, work_next;
  logic                  fill, fill_next;
  logic [RW-1:0]         remaining, remaining_next;

  logic [RW-1:0]         load_amount;
  logic [RW-1:0]         step_k;
  logic [DATA_WIDTH-1:0] work_shifted;

  // Counts of DATA_WIDTH or more all collapse to a full-width shift.
  assign load_amount = (shift_amount >= DATA_WIDTH'(DATA_WIDTH)) ? REM_FULL
                                                                 : shift_amount[RW-1:0];
  assign step_k      = (remaining < REM_STEP) ? remaining : REM_STEP;
  // Inverting around a logical shift turns the zero fill into a ones fill.
  assign work_shifted = fill ? ~(~work >> step_k) : (work >> step_k);

  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next     = state;
    work_next      = work;
    fill_next      = fill;
    remaining_next = remaining;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          work_next      = data_in;
          fill_next      = arith & data_in[DATA_WIDTH-1];
          remaining_next = load_amount;
          state_next     = (load_amount != '0) ? SHIFT : DONE;
        end else if (state == DONE) begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        work_next      = work_shifted;
        remaining_next = remaining - step_k;
        if (remaining_next == '0) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      fill      <= 1'b0;
      remaining <= '0;
    end else begin
      state     <= state_next;
      work      <= work_next;
      fill      <= fill_next;
      remaining <= remaining_next;
    end
  end

  assign busy     = (state == SHIFT);
  assign done     = (state == DONE);
  assign data_out = work;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer with hand-computed results.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] data_in;
  logic [19:0] shift_amount;
  logic        arith;
  logic        busy;
  logic        done;
  logic [19:0] data_out;

  int checks   = 0;
  int failures = 0;

  shift_sequencer #(.DATA_WIDTH(20), .STEP(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .data_in      (data_in),
    .shift_amount (shift_amount),
    .arith        (arith),
    .busy         (busy),
    .done         (done),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic b, input logic d);
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_done"}, 32'(done), 32'(d));
  endtask

  // Issue one operation, scramble operands after acceptance, and verify the
  // exact number of SHIFT cycles, the done pulse and the held result.
  task automatic run_op(input string tag, input logic [19:0] d, input logic [19:0] amt,
                        input logic a, input logic [19:0] exp, input int cycles);
    data_in      = d;
    shift_amount = amt;
    arith        = a;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    data_in      = 20'h5A5A5;
    shift_amount = 20'h00003;
    arith        = ~a;
    for (int i = 0; i < cycles; i++) begin
      check_status({tag, "_shift"}, 1'b1, 1'b0);
      tick();
    end
    check_status({tag, "_end"}, 1'b0, 1'b1);
    check({tag, "_data"}, 32'(data_out), 32'(exp));
    tick();
    check_status({tag, "_idle"}, 1'b0, 1'b0);
    check({tag, "_hold"}, 32'(data_out), 32'(exp));
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    data_in      = '0;
    shift_amount = '0;
    arith        = 1'b0;
    #2;
    check_status("rst_async", 1'b0, 1'b0);
    check("rst_async_data", 32'(data_out), 32'h0);
    tick();
    tick();
    check_status("rst_held", 1'b0, 1'b0);
    check("rst_held_data", 32'(data_out), 32'h0);
    rst = 1'b0;

    // First operation right after reset release is accepted on the next edge.
    run_op("lsr3", 20'hAAAAA, 20'd3, 1'b0, 20'h15555, 1);
    run_op("lsr7", 20'h8A8AA, 20'd7, 1'b0, 20'h01151, 2);
    run_op("asr7", 20'h8A8AA, 20'd7, 1'b1, 20'hFF151, 2);
    run_op("zero", 20'h12345, 20'd0, 1'b1, 20'h12345, 0);
    run_op("asr25", 20'h80000, 20'd25, 1'b1, 20'hFFFFF, 5);
    run_op("lsr25", 20'h80000, 20'd25, 1'b0, 20'h00000, 5);
    run_op("asr4_pos", 20'h7FFFF, 20'd4, 1'b1, 20'h07FFF, 1);
    run_op("asr20", 20'hC0000, 20'd20, 1'b1, 20'hFFFFF, 5);
    run_op("lsr19", 20'h80000, 20'd19, 1'b0, 20'h00001, 5);

    // Start pulsed during SHIFT with other operands is ignored.
    data_in = 20'h8A8AA; shift_amount = 20'd7; arith = 1'b0; start = 1'b1;
    tick();
    data_in = 20'h12345; shift_amount = 20'd0; arith = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check_status("ign_mid", 1'b1, 1'b0);
    tick();
    check_status("ign_end", 1'b0, 1'b1);
    check("ign_data", 32'(data_out), 32'h01151);
    tick();
    check_status("ign_idle", 1'b0, 1'b0);

    // Start held through DONE: back-to-back with no IDLE cycle.
    data_in = 20'hAAAAA; shift_amount = 20'd3; arith = 1'b0; start = 1'b1;
    tick();
    data_in = 20'h80000; shift_amount = 20'd4; arith = 1'b1;
    check_status("b2b_a_shift", 1'b1, 1'b0);
    tick();
    check_status("b2b_a_done", 1'b0, 1'b1);
    check("b2b_a_data", 32'(data_out), 32'h15555);
    tick();
    data_in = 20'h12345; shift_amount = 20'd0; arith = 1'b0;
    check_status("b2b_b_shift", 1'b1, 1'b0);
    tick();
    check_status("b2b_b_done", 1'b0, 1'b1);
    check("b2b_b_data", 32'(data_out), 32'hF8000);
    tick();
    start = 1'b0;
    check_status("b2b_c_done", 1'b0, 1'b1);
    check("b2b_c_data", 32'(data_out), 32'h12345);
    tick();
    check_status("b2b_idle", 1'b0, 1'b0);

    // Reset asserted mid-shift aborts immediately; no done pulse follows.
    data_in = 20'hFFFFF; shift_amount = 20'd20; arith = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_status("abort_pre", 1'b1, 1'b0);
    check("abort_pre_data", 32'(data_out), 32'h0FFFF);
    #2;
    rst = 1'b1;
    #1;
    check_status("abort_rst", 1'b0, 1'b0);
    check("abort_rst_data", 32'(data_out), 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_status("abort_quiet", 1'b0, 1'b0);
      tick();
    end
    check("abort_quiet_data", 32'(data_out), 32'h0);
    run_op("post_abort", 20'hF0F0F, 20'd8, 1'b1, 20'hFFF0F, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
